// File: rtl/mem_dreq_issue.sv
// mem_dreq_issue: MEM-stage data-bus request issuer feeding MEM2.
// Accepts one memory-class instruction at a time, checks alignment,
// builds byte strobes and replicated store data, issues the request on
// the cpu_dbus valid/ready handshake and hands MEM2 a registered record.
//
// Handshake semantics (both the in_* and dbus_* sides): a transfer occurs
// at a rising clk edge where valid and ready are both high; valid never
// depends on ready, and request fields hold steady while valid is pending.
//
// Optional feature: define MEM_DREQ_PERF_EN to add perf_req_cnt (handshake
// count) and perf_wait_cnt (cycles spent in REQ with dbus_ready low).
module mem_dreq_issue #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [ADDR_W-1:0] in_wdata,
    output logic              dbus_valid,
    input  logic              dbus_ready,
    output logic              dbus_wr,
    output logic [1:0]        dbus_size,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_wstrb,
    output logic [ADDR_W-1:0] dbus_wdata,
    input  logic              mem2_allowin,
    output logic              out_valid,
    output logic [3:0]        out_op,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_adel,
    output logic              out_ades,
    output logic              out_bus,
`ifdef MEM_DREQ_PERF_EN
    output logic [31:0]       perf_req_cnt,
    output logic [31:0]       perf_wait_cnt,
`endif
    output logic [0:0]        dbg_state
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]        r_state;
    logic [3:0]        r_op;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wstrb;
    logic [ADDR_W-1:0] r_wdata;

    logic              r_out_valid;
    logic [3:0]        r_out_op;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_adel;
    logic              r_out_ades;
    logic              r_out_bus;

    logic              w_is_load;
    logic              w_is_store;
    logic [1:0]        w_size;
    logic [3:0]        w_op;
    logic              w_misalign;
    logic [3:0]        w_wstrb;
    logic [ADDR_W-1:0] w_wdata;
    logic              w_capture;
    logic              w_bus_op;
    logic              w_dbus_valid;
    logic              w_hs;

    // Decode op class and access size; unknown codes collapse to NONE.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = 2'd0;
        w_op       = in_op;
        case (in_op)
            4'd1, 4'd2: begin w_is_load  = 1'b1; w_size = 2'd0; end
            4'd3, 4'd4: begin w_is_load  = 1'b1; w_size = 2'd1; end
            4'd5:       begin w_is_load  = 1'b1; w_size = 2'd2; end
            4'd9:       begin w_is_store = 1'b1; w_size = 2'd0; end
            4'd10:      begin w_is_store = 1'b1; w_size = 2'd1; end
            4'd11:      begin w_is_store = 1'b1; w_size = 2'd2; end
            default:    w_op = 4'd0;
        endcase
    end

    // Alignment check, byte strobes and lane-replicated store data.
    always_comb begin
        w_misalign = ((w_size == 2'd1) && in_addr[0]) ||
                     ((w_size == 2'd2) && (in_addr[1:0] != 2'b00));
        w_wstrb    = 4'b0000;
        w_wdata    = '0;
        if (w_is_store) begin
            case (w_size)
                2'd0: begin
                    w_wstrb = 4'b0001 << in_addr[1:0];
                    w_wdata = {4{in_wdata[7:0]}};
                end
                2'd1: begin
                    w_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{in_wdata[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = in_wdata;
                end
            endcase
        end
    end

    // Accept/issue qualifiers; a flush or a stalled MEM2 masks the request.
    always_comb begin
        in_ready     = (r_state == S_IDLE) && (!r_out_valid || mem2_allowin);
        w_capture    = in_valid && in_ready && !mem_flush;
        w_bus_op     = (w_is_load || w_is_store) && !w_misalign;
        w_dbus_valid = (r_state == S_REQ) && !mem_flush && mem2_allowin;
        w_hs         = w_dbus_valid && dbus_ready;
    end

    // Request FSM: IDLE until an aligned memory op is captured, REQ until
    // the D-cache accepts or a flush kills the request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_capture && w_bus_op) r_state <= S_REQ;
                S_REQ:  if (mem_flush || w_hs)     r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request fields latch at capture and stay stable through REQ.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op    <= 4'd0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wstrb <= 4'b0000;
            r_wdata <= '0;
        end else if (w_capture && w_bus_op) begin
            r_op    <= w_op;
            r_wr    <= w_is_store;
            r_size  <= w_size;
            r_addr  <= in_addr;
            r_wstrb <= w_wstrb;
            r_wdata <= w_wdata;
        end
    end

    // MEM2 record: loaded on handshake or on a non-bus capture, dropped
    // when MEM2 takes it or a flush arrives.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_out_op    <= 4'd0;
            r_out_addr  <= '0;
            r_out_adel  <= 1'b0;
            r_out_ades  <= 1'b0;
            r_out_bus   <= 1'b0;
        end else if (w_hs) begin
            r_out_valid <= 1'b1;
            r_out_op    <= r_op;
            r_out_addr  <= r_addr;
            r_out_adel  <= 1'b0;
            r_out_ades  <= 1'b0;
            r_out_bus   <= 1'b1;
        end else if (w_capture && !w_bus_op) begin
            r_out_valid <= 1'b1;
            r_out_op    <= w_op;
            r_out_addr  <= in_addr;
            r_out_adel  <= w_is_load && w_misalign;
            r_out_ades  <= w_is_store && w_misalign;
            r_out_bus   <= 1'b0;
        end else if (mem_flush || mem2_allowin) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MEM_DREQ_PERF_EN
    logic [31:0] r_perf_req_cnt;
    logic [31:0] r_perf_wait_cnt;

    // Free-running wrap-around counters of handshakes and stalled REQ cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_req_cnt  <= 32'd0;
            r_perf_wait_cnt <= 32'd0;
        end else begin
            if (w_hs)
                r_perf_req_cnt <= r_perf_req_cnt + 32'd1;
            if ((r_state == S_REQ) && !dbus_ready)
                r_perf_wait_cnt <= r_perf_wait_cnt + 32'd1;
        end
    end

    assign perf_req_cnt  = r_perf_req_cnt;
    assign perf_wait_cnt = r_perf_wait_cnt;
`endif

    assign dbus_valid = w_dbus_valid;
    assign dbus_wr    = r_wr;
    assign dbus_size  = r_size;
    assign dbus_addr  = r_addr;
    assign dbus_wstrb = r_wstrb;
    assign dbus_wdata = r_wdata;
    assign out_valid  = r_out_valid;
    assign out_op     = r_out_op;
    assign out_addr   = r_out_addr;
    assign out_adel   = r_out_adel;
    assign out_ades   = r_out_ades;
    assign out_bus    = r_out_bus;
    assign dbg_state  = r_state;

endmodule
